// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide controller: op codes, FSM states, helpers.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
    localparam logic [6:0] FUNCT7_M     = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_controller_div_core.sv
// Restoring unsigned divider: loads on div_start, then retires one quotient bit per cycle for 32 cycles.
import muldiv_pkg::*;

module div_core #(
    parameter int XLEN = muldiv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            div_start,
    input  logic            kill,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            div_done
);

    localparam logic [4:0] LAST = 5'(XLEN - 1);

    logic [XLEN-1:0] dvs_q;
    logic [4:0]      count;
    logic            active;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            fits;

    // The dividend shifts out of the quotient register MSB-first into the partial remainder.
    assign shifted = {remainder, quotient[XLEN-1]};
    assign fits    = shifted >= {1'b0, dvs_q};
    assign diff    = shifted[XLEN-1:0] - dvs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient  <= '0;
            remainder <= '0;
            dvs_q     <= '0;
            count     <= '0;
            active    <= 1'b0;
        end else if (kill) begin
            count  <= '0;
            active <= 1'b0;
        end else if (div_start) begin
            quotient  <= dividend;
            remainder <= '0;
            dvs_q     <= divisor;
            count     <= '0;
            active    <= 1'b1;
        end else if (active) begin
            remainder <= fits ? diff : shifted[XLEN-1:0];
            quotient  <= {quotient[XLEN-2:0], fits};
            count     <= count + 5'd1;
            if (count == LAST) begin
                active <= 1'b0;
            end
        end
    end

    assign div_done = active && (count == LAST);

endmodule

// File: rtl/muldiv_controller.sv
// Sequences RV32M ops in EX: registered multiply, iterative divide, and fast paths for trivial divides.
// Define MULDIV_REUSE_EN to keep the last divide's quotient/remainder and answer repeats without stalling.
import muldiv_pkg::*;

module muldiv_controller #(
    parameter int XLEN       = muldiv_pkg::XLEN,
    parameter int MUL_STAGES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            kill,
    output logic            md_stall,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic            busy
);

    md_state_t state;

    logic [1:0]      mul_cnt;
    logic [XLEN-1:0] result_q;
    logic            is_div_q;
    logic            neg_q_q;
    logic            neg_r_q;
    logic            rem_sel_q;

    logic is_div, div_signed, want_rem;
    logic accept, mul_go, div_start, fast_hit, reuse_hit, done_now;
    logic div_by_zero, div_ovf;
    logic [XLEN-1:0] fast_val, reuse_val, div_q_fix, div_r_fix, done_val;

    logic                   mul_sa, mul_sb;
    logic signed [XLEN:0]   mul_a, mul_b;
    logic signed [2*XLEN-1:0] product;
    logic [XLEN-1:0]        mul_word;

    logic [XLEN-1:0] quotient, remainder;
    logic            div_done;

    assign is_div     = funct3[2];
    assign div_signed = ~funct3[0];
    assign want_rem   = funct3[1];

    assign accept      = start && !kill && (state == ST_IDLE);
    assign div_by_zero = (operand_b == '0);
    assign div_ovf     = div_signed && (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (&operand_b);
    assign fast_hit    = accept && is_div && (div_by_zero || div_ovf);
    assign fast_val    = div_by_zero ? (want_rem ? operand_a : '1)
                                     : (want_rem ? '0 : operand_a);

    assign mul_go    = accept && !is_div;
    assign div_start = accept && is_div && !fast_hit && !reuse_hit;

    // 33x33 signed product; the extra bit carries the sign only for the signed operand(s).
    assign mul_sa   = (funct3 == F3_MULH) || (funct3 == F3_MULHSU);
    assign mul_sb   = (funct3 == F3_MULH);
    assign mul_a    = {mul_sa & operand_a[XLEN-1], operand_a};
    assign mul_b    = {mul_sb & operand_b[XLEN-1], operand_b};
    assign product  = (2*XLEN)'(mul_a) * (2*XLEN)'(mul_b);
    assign mul_word = (funct3 == F3_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

    div_core #(.XLEN(XLEN)) u_div_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .div_start (div_start),
        .kill      (kill),
        .dividend  (abs_val(operand_a, div_signed)),
        .divisor   (abs_val(operand_b, div_signed)),
        .quotient  (quotient),
        .remainder (remainder),
        .div_done  (div_done)
    );

    assign div_q_fix = neg_if(quotient, neg_q_q);
    assign div_r_fix = neg_if(remainder, neg_r_q);
    assign done_val  = is_div_q ? (rem_sel_q ? div_r_fix : div_q_fix) : result_q;

`ifdef MULDIV_REUSE_EN
    logic [XLEN-1:0] last_a, last_b, last_q, last_r;
    logic            last_signed, last_valid;

    // Operands are captured when a divide issues; the results become usable once it completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_a      <= '0;
            last_b      <= '0;
            last_q      <= '0;
            last_r      <= '0;
            last_signed <= 1'b0;
            last_valid  <= 1'b0;
        end else if (kill) begin
            last_valid <= 1'b0;
        end else if (div_start) begin
            last_a      <= operand_a;
            last_b      <= operand_b;
            last_signed <= div_signed;
            last_valid  <= 1'b0;
        end else if (fast_hit) begin
            last_valid <= 1'b0;
        end else if (state == ST_DONE && is_div_q) begin
            last_q     <= div_q_fix;
            last_r     <= div_r_fix;
            last_valid <= 1'b1;
        end
    end

    assign reuse_hit = accept && is_div && !fast_hit && last_valid &&
                       (operand_a == last_a) && (operand_b == last_b) && (div_signed == last_signed);
    assign reuse_val = want_rem ? last_r : last_q;
`else
    assign reuse_hit = 1'b0;
    assign reuse_val = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mul_cnt   <= '0;
            result_q  <= '0;
            is_div_q  <= 1'b0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            rem_sel_q <= 1'b0;
        end else if (kill) begin
            state   <= ST_IDLE;
            mul_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mul_go) begin
                        result_q <= mul_word;
                        is_div_q <= 1'b0;
                        mul_cnt  <= '0;
                        state    <= (MUL_STAGES > 1) ? ST_MUL : ST_DONE;
                    end else if (div_start) begin
                        is_div_q  <= 1'b1;
                        neg_q_q   <= div_signed && (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
                        neg_r_q   <= div_signed && operand_a[XLEN-1];
                        rem_sel_q <= want_rem;
                        state     <= ST_DIV;
                    end
                end
                ST_MUL: begin
                    if (int'(mul_cnt) == MUL_STAGES - 2) begin
                        state <= ST_DONE;
                    end else begin
                        mul_cnt <= mul_cnt + 2'd1;
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign done_now     = (state == ST_DONE) && !kill;
    assign busy         = (state != ST_IDLE);
    assign result_valid = rst_n && (done_now || fast_hit || reuse_hit);
    assign md_stall     = rst_n && start && !kill &&
                          (((state == ST_IDLE) && !fast_hit && !reuse_hit) ||
                           (state == ST_MUL) || (state == ST_DIV));
    assign result       = !rst_n    ? '0       :
                          fast_hit  ? fast_val :
                          reuse_hit ? reuse_val :
                          done_now  ? done_val : '0;

    // The instruction must stay in EX while the unit is working on it.
    start_held: assert property (@(posedge clk) disable iff (!rst_n)
        ((state == ST_MUL || state == ST_DIV) && !kill) |-> start);

endmodule

// File: tb/tb_muldiv_controller.sv
// Directed self-checking bench for muldiv_controller (default MUL_STAGES=1).
import muldiv_pkg::*;

module tb_muldiv_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        md_stall;
    logic        result_valid;
    logic        busy;
    logic [31:0] result;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          stalls;
    int          lat;
    logic [31:0] res;

    always #5 clk = ~clk;

    muldiv_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .funct3       (funct3),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .kill         (kill),
        .md_stall     (md_stall),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy)
    );

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Issues one op, holds start until result_valid (bounded), then releases start after DONE.
    task automatic apply_stimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                  output int n_stall, output int latency, output logic [31:0] value);
        n_stall = 0;
        latency = -1;
        value   = '0;
        @(posedge clk); #1;
        start = 1'b1; funct3 = f3; operand_a = a; operand_b = b;
        for (int c = 0; c < 60 && latency < 0; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                operand_a = ~a; operand_b = ~b;
            end
            #1;
            if (md_stall === 1'b1) n_stall++;
            if (result_valid === 1'b1) begin
                latency = c;
                value   = result;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        #1;
        check_output("reset_busy",   {31'd0, busy},         32'd0);
        check_output("reset_valid",  {31'd0, result_valid}, 32'd0);
        check_output("reset_result", result,                32'd0);
        check_output("reset_stall",  {31'd0, md_stall},     32'd0);
        #21 rst_n = 1'b1;

        apply_stimulus(F3_MUL, 32'd7, 32'hFFFFFFFD, stalls, lat, res);
        check_output("mul_stalls", 32'(stalls), 32'd1);
        check_output("mul_lat",    32'(lat),    32'd1);
        check_output("mul_result", res,         32'hFFFFFFEB);

        apply_stimulus(F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, stalls, lat, res);
        check_output("mulhu_result", res,         32'hFFFFFFFE);
        check_output("mulhu_stalls", 32'(stalls), 32'd1);

        apply_stimulus(F3_MULHSU, 32'hFFFFFFFF, 32'd2, stalls, lat, res);
        check_output("mulhsu_result", res, 32'hFFFFFFFF);

        apply_stimulus(F3_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, stalls, lat, res);
        check_output("mulh_result", res, 32'h00000000);

        apply_stimulus(F3_DIV, 32'hFFFFFFEC, 32'd3, stalls, lat, res);
        check_output("div_stalls", 32'(stalls), 32'd33);
        check_output("div_lat",    32'(lat),    32'd33);
        check_output("div_result", res,         32'hFFFFFFFA);

        apply_stimulus(F3_REM, 32'hFFFFFFEC, 32'd3, stalls, lat, res);
        check_output("rem_result", res, 32'hFFFFFFFE);

        apply_stimulus(F3_DIVU, 32'd100, 32'd0, stalls, lat, res);
        check_output("divu0_result", res,         32'hFFFFFFFF);
        check_output("divu0_lat",    32'(lat),    32'd0);
        check_output("divu0_stalls", 32'(stalls), 32'd0);

        apply_stimulus(F3_REMU, 32'd100, 32'd0, stalls, lat, res);
        check_output("remu0_result", res, 32'd100);

        apply_stimulus(F3_REM, 32'h80000000, 32'hFFFFFFFF, stalls, lat, res);
        check_output("removf_result", res,         32'h00000000);
        check_output("removf_lat",    32'(lat),    32'd0);
        check_output("removf_stalls", 32'(stalls), 32'd0);

        apply_stimulus(F3_DIV, 32'h80000000, 32'hFFFFFFFF, stalls, lat, res);
        check_output("divovf_result", res, 32'h80000000);

        // Kill a divide in its tenth cycle.
        @(posedge clk); #1;
        start = 1'b1; funct3 = F3_DIV; operand_a = 32'hFFFFFFEC; operand_b = 32'd3;
        repeat (10) begin @(posedge clk); #1; end
        check_output("kill_busy_before", {31'd0, busy}, 32'd1);
        kill = 1'b1; #1;
        check_output("kill_stall",  {31'd0, md_stall},     32'd0);
        check_output("kill_valid",  {31'd0, result_valid}, 32'd0);
        @(posedge clk); #1;
        kill = 1'b0; start = 1'b0; #1;
        check_output("kill_idle",        {31'd0, busy},         32'd0);
        check_output("kill_after_stall", {31'd0, md_stall},     32'd0);
        check_output("kill_after_valid", {31'd0, result_valid}, 32'd0);

        apply_stimulus(F3_DIVU, 32'd9, 32'd2, stalls, lat, res);
        check_output("divu_post_kill_result", res,      32'd4);
        check_output("divu_post_kill_lat",    32'(lat), 32'd33);

        // Reset in the middle of a divide.
        @(posedge clk); #1;
        start = 1'b1; funct3 = F3_DIV; operand_a = 32'd1000; operand_b = 32'd7;
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0; #1;
        check_output("rst_mid_busy",   {31'd0, busy},         32'd0);
        check_output("rst_mid_stall",  {31'd0, md_stall},     32'd0);
        check_output("rst_mid_valid",  {31'd0, result_valid}, 32'd0);
        check_output("rst_mid_result", result,                32'd0);
        start = 1'b0;
        #4 rst_n = 1'b1;

        apply_stimulus(F3_DIVU, 32'hFFFFFFFE, 32'h10, stalls, lat, res);
        check_output("divu_big_result", res, 32'h0FFFFFFF);
        apply_stimulus(F3_REMU, 32'hFFFFFFFE, 32'h10, stalls, lat, res);
        check_output("remu_big_result", res, 32'h0000000E);

        apply_stimulus(F3_DIV, 32'd50, 32'd7, stalls, lat, res);
        check_output("div50_result", res,      32'd7);
        check_output("div50_lat",    32'(lat), 32'd33);
        apply_stimulus(F3_REM, 32'd50, 32'd7, stalls, lat, res);
        check_output("rem50_result", res, 32'd1);
`ifdef MULDIV_REUSE_EN
        check_output("rem50_reuse_lat",    32'(lat),    32'd0);
        check_output("rem50_reuse_stalls", 32'(stalls), 32'd0);
`else
        check_output("rem50_lat",    32'(lat),    32'd33);
        check_output("rem50_stalls", 32'(stalls), 32'd33);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no completion, expected finish before 100000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
